vga_plot_arbiter: RTL

//  Shares the single VGA adapter pixel-write port (x[7:0], y[6:0], colour[2:0], writeEn) among four

---
 rtl/vga_plot_arbiter_if.sv | 29 ++
 rtl/vga_plot_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter_if.sv
// Pixel-write bus between four draw engines and the VGA adapter port, plus frame control/status.
// master = draw-engine side (drives requests), slave = arbiter side (drives grants and plot outputs).
interface vga_plot_arbiter_if;
   logic        frame_start;
   logic [3:0]  en_mask;
   logic [3:0]  req;
   logic [3:0]  req_last;
   logic [31:0] req_x;
   logic [27:0] req_y;
   logic [11:0] req_colour;
   logic [3:0]  gnt;
   logic [7:0]  plot_x;
   logic [6:0]  plot_y;
   logic [2:0]  plot_colour;
   logic        plot_writeEn;
   logic        frame_busy;
   logic        frame_done;
   logic        overrun;

   modport master (
      output frame_start, en_mask, req, req_last, req_x, req_y, req_colour,
      input  gnt, plot_x, plot_y, plot_colour, plot_writeEn, frame_busy, frame_done, overrun
   );

   modport slave (
      input  frame_start, en_mask, req, req_last, req_x, req_y, req_colour,
      output gnt, plot_x, plot_y, plot_colour, plot_writeEn, frame_busy, frame_done, overrun
   );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing one VGA pixel-write port among four requesters; one frame per frame_start.
// Pixel appears on plot_* one cycle after acceptance; requesters are stalled by gnt=0 (one ARB cycle between bursts).
module vga_plot_arbiter #(
   parameter int MAX_BURST   = 64,
   parameter bit ERASE_FIRST = 1'b1
) (
   input  logic                Clock,
   input  logic                reset,
   vga_plot_arbiter_if.slave   bus
);
   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [3:0]     r_en_q;
   logic [3:0]     r_done_mask;
   logic [1:0]     r_rr_ptr;
   logic [1:0]     r_owner;
   logic [CW-1:0]  r_burst_cnt;
   logic [7:0]     r_plot_x;
   logic [6:0]     r_plot_y;
   logic [2:0]     r_plot_colour;
   logic           r_plot_we;
   logic           r_frame_busy;
   logic           r_frame_done;
   logic           r_overrun;

   logic [3:0]     w_elig;
   logic           w_found;
   logic [1:0]     w_pick;
   logic           w_fs_ok;
   logic           w_all_done;
   logic           w_own_req;
   logic           w_own_last;
   logic           w_accept;
   logic [CW-1:0]  w_cnt_nxt;
   logic           w_burst_full;
   logic           w_release;
   logic [7:0]     w_x;
   logic [6:0]     w_y;
   logic [2:0]     w_c;
   logic [3:0]     w_gnt;

   // A frame_start landing on the frame_done cycle belongs to the finished frame and is dropped.
   assign w_fs_ok      = bus.frame_start && !r_frame_done;
   assign w_all_done   = (r_done_mask == r_en_q);
   assign w_own_req    = bus.req[r_owner];
   assign w_own_last   = bus.req_last[r_owner];
   assign w_accept     = (r_state == S_BURST) && w_own_req;
   assign w_cnt_nxt    = r_burst_cnt + CW'(1);
   assign w_burst_full = (w_cnt_nxt == CW'(MAX_BURST));
   assign w_release    = (r_state == S_BURST) && (!w_own_req || w_own_last || w_burst_full);

   always_comb begin
      w_elig = bus.req & r_en_q & ~r_done_mask;
      if (ERASE_FIRST && r_en_q[0] && !r_done_mask[0])
         w_elig = w_elig & 4'b0001;
   end

   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      for (int k = 0; k < 4; k++) begin
         if (!w_found && w_elig[r_rr_ptr + 2'(k)]) begin
            w_found = 1'b1;
            w_pick  = r_rr_ptr + 2'(k);
         end
      end
   end

   always_comb begin
      w_x = bus.req_x[7:0];
      w_y = bus.req_y[6:0];
      w_c = bus.req_colour[2:0];
      case (r_owner)
         2'd1:    begin w_x = bus.req_x[15:8];  w_y = bus.req_y[13:7];  w_c = bus.req_colour[5:3];  end
         2'd2:    begin w_x = bus.req_x[23:16]; w_y = bus.req_y[20:14]; w_c = bus.req_colour[8:6];  end
         2'd3:    begin w_x = bus.req_x[31:24]; w_y = bus.req_y[27:21]; w_c = bus.req_colour[11:9]; end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_fs_ok) w_next = S_ARB;
         S_ARB: begin
            if (w_all_done)   w_next = S_IDLE;
            else if (w_found) w_next = S_BURST;
         end
         S_BURST: if (w_release) w_next = S_ARB;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_gnt = 4'b0000;
      if (r_state == S_BURST)
         w_gnt = 4'b0001 << r_owner;
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         r_en_q        <= 4'b0;
         r_done_mask   <= 4'b0;
         r_rr_ptr      <= 2'd0;
         r_owner       <= 2'd0;
         r_burst_cnt   <= '0;
         r_plot_x      <= 8'd0;
         r_plot_y      <= 7'd0;
         r_plot_colour <= 3'd0;
         r_plot_we     <= 1'b0;
         r_frame_busy  <= 1'b0;
         r_frame_done  <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_plot_we    <= w_accept;
         if (w_accept) begin
            r_plot_x      <= w_x;
            r_plot_y      <= w_y;
            r_plot_colour <= w_c;
         end
         if (bus.frame_start && r_frame_busy)
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_fs_ok) begin
                  r_en_q       <= bus.en_mask;
                  r_done_mask  <= 4'b0;
                  r_frame_busy <= 1'b1;
               end
            end
            S_ARB: begin
               if (w_all_done) begin
                  r_frame_done <= 1'b1;
                  r_frame_busy <= 1'b0;
               end else if (w_found) begin
                  r_owner     <= w_pick;
                  r_burst_cnt <= '0;
               end
            end
            S_BURST: begin
               if (w_accept)
                  r_burst_cnt <= w_cnt_nxt;
               if (w_accept && w_own_last)
                  r_done_mask[r_owner] <= 1'b1;
               if (w_release)
                  r_rr_ptr <= r_owner + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.gnt          = w_gnt;
   assign bus.plot_x       = r_plot_x;
   assign bus.plot_y       = r_plot_y;
   assign bus.plot_colour  = r_plot_colour;
   assign bus.plot_writeEn = r_plot_we;
   assign bus.frame_busy   = r_frame_busy;
   assign bus.frame_done   = r_frame_done;
   assign bus.overrun      = r_overrun;
endmodule
